ifu_fetch_ctrl: RTL
===================

// Module: ifu_fetch_ctrl
// PURPOSE
//  Front-end fetch controller upstream of the IF/ID pipe register. Owns the fetch PC and issues in-order
//  requests on the instruction-memory valid/ready port. Buffers returned words with their addresses in a
//  small prefetch FIFO and presents one instruction per cycle to the IF register. On a jump it redirects
//  the PC, flushes the FIFO and drops stale in-flight responses.
// PARAMETERS
//  FIFO_DEPTH      4          prefetch entries (power of 2, >=2)
//  MAX_OUTSTANDING 2          max requests accepted by memory but not yet answered (>=1)
//  RESET_PC        32'h0      first fetch address after reset
// PORTS
//  clk            in   1                   clock
//  rst            in   1                   synchronous reset, active-high
//  jump_flag_i    in   1                   redirect request from EX/CSR
//  jump_addr_i    in   INST_ADDR_WIDTH     redirect target
//  hold_flag_i    in   Hold_Flag_Bus       pipeline stall; IF consumes only when hold_flag_i < Hold_If
//  req_valid_o    out  1                   fetch request valid
//  req_addr_o     out  INST_ADDR_WIDTH     fetch address (word aligned)
//  req_ready_i    in   1                   memory accepts request
//  rsp_valid_i    in   1                   response valid (in order, never back-pressured)
//  rsp_data_i     in   INST_DATA_WIDTH     response instruction word
//  inst_o         out  INST_DATA_WIDTH     instruction to IF register
//  inst_addr_o    out  INST_ADDR_WIDTH     its address
//  inst_valid_o   out  1                   FIFO head valid
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0; req_valid_o=0 in reset cycle;
//    inst_o=INST_NOP, inst_addr_o=ZeroWord, inst_valid_o=0.
//  - Issue: req_valid_o = !jump_flag_i && (outstanding < MAX_OUTSTANDING) &&
//    (outstanding + fifo_count < FIFO_DEPTH); req_addr_o = pc. Handshake = valid&&ready; on handshake
//    pc<=pc+4, outstanding++. Address held stable while valid&&!ready.
//  - Response: rsp_valid_i with drop_cnt==0 -> push {rsp_data_i, addr}. Addr comes from a tag queue of
//    issued PCs (depth MAX_OUTSTANDING). With drop_cnt>0 -> discard, drop_cnt--. Either way outstanding--.
//    The credit rule guarantees a push never finds the FIFO full; a push when full is an assertion failure.
//  - Output: empty -> inst_o=INST_NOP, inst_addr_o=ZeroWord, valid=0 (combinational from head).
//    Pop when valid && hold_flag_i < Hold_If. Latency: issue->earliest IF capture = mem latency + 1.
//  - Simultaneous push/pop on non-empty FIFO: count unchanged. Push into an empty FIFO is visible next cycle
//    (no bypass).
//  - Jump (highest priority): FIFO cleared; pc<=jump_addr_i; no request issued that cycle.
//    drop_cnt <= outstanding (+1 if a handshake lands that cycle) (-1 if a response arrives that cycle);
//    any response that cycle is discarded. Jump during a hold is still taken. Back-to-back jumps accumulate
//    correctly; the last target wins.
//  - Counter widths: clog2(MAX_OUTSTANDING+1) for outstanding/drop_cnt; FIFO pointers wrap modulo
//    FIFO_DEPTH, with an extra wrap bit for full/empty.
//  - Reset mid-operation: all state cleared in one cycle; responses after reset are ignored, because
//    memory is reset by the same rst.
// CONFIGURATION
//  IFU_MISALIGN_CHK_EN defined: adds output misalign_o (1). A jump_addr_i[1:0]!=0 sets a sticky
//  misalign_o=1 and blocks issue until the next jump or rst, and the FIFO stays empty. misalign_o
//  resets to 0.
//  Undefined: no port; jump_addr_i[1:0] forced to 0 before loading the PC.
// STRUCTURE
//  - Constants INST_NOP, ZeroWord, Hold_If, Hold_Flag_Bus and the widths come from defines.v.
//  - Add IFU_FIFO_DEPTH and IFU_MAX_OUTSTANDING defaults to defines.v.
//  - Sub-module ifu_inst_fifo: sync FIFO of {addr,data}, ports push/pop/flush/count/head. It is also reused
//    for the tag queue.
//  - The top holds the PC, credit and drop logic.
// TESTING
//  1. Reset, req_ready_i=1, 1-cycle mem -> addresses 0,4,8,.. issued; inst_o sequence matches; no gaps.
//  2. req_ready_i=0 for 5 cycles -> req_addr_o held at 0x8, no duplicate or skipped address.
//  3. hold_flag_i=Hold_If for 6 cycles -> FIFO fills to 4, req_valid_o drops; on release 4 pops in order.
//  4. Jump to 0x100 with 2 outstanding -> both stale rsps dropped, next inst_addr_o=0x100.
//  5. Jump in the same cycle as a handshake and a response -> drop_cnt correct, no stale word emitted.
//  6. IFU_MISALIGN_CHK_EN: jump to 0x102 -> misalign_o=1, no requests; jump to 0x200 clears it.

Source files
------------

// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared constants, widths and types for the instruction fetch front end.
// Optional misalignment checking in ifu_fetch_ctrl is enabled by IFU_MISALIGN_CHK_EN.
package ifu_fetch_ctrl_pkg;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_DATA_WIDTH = 32;
  localparam int HOLD_FLAG_WIDTH = 3;

  localparam logic [INST_DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [INST_ADDR_WIDTH-1:0] ZeroWord = 32'h0;

  typedef logic [HOLD_FLAG_WIDTH-1:0] hold_flag_t;
  localparam hold_flag_t Hold_None = 3'd0;
  localparam hold_flag_t Hold_Pc   = 3'd1;
  localparam hold_flag_t Hold_If   = 3'd2;
  localparam hold_flag_t Hold_Id   = 3'd3;

  localparam int IFU_FIFO_DEPTH      = 4;
  localparam int IFU_MAX_OUTSTANDING = 2;

  typedef struct packed {
    logic [INST_ADDR_WIDTH-1:0] addr;
    logic [INST_DATA_WIDTH-1:0] data;
  } fetch_entry_t;

  function automatic logic [INST_ADDR_WIDTH-1:0] align_word(input logic [INST_ADDR_WIDTH-1:0] a);
    return {a[INST_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_inst_fifo.sv
// Synchronous FIFO used both as the prefetch buffer and as the issued-PC tag queue.
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit.
module ifu_inst_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == PW'(DEPTH));
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: owns the PC, issues credit-limited requests, buffers responses, handles redirects.
// Define IFU_MISALIGN_CHK_EN to add the sticky misalign_o output that blocks issue on unaligned jumps.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int                         FIFO_DEPTH      = IFU_FIFO_DEPTH,
  parameter int                         MAX_OUTSTANDING = IFU_MAX_OUTSTANDING,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       jump_flag_i,
  input  logic [INST_ADDR_WIDTH-1:0] jump_addr_i,
  input  logic [HOLD_FLAG_WIDTH-1:0] hold_flag_i,
  output logic                       req_valid_o,
  output logic [INST_ADDR_WIDTH-1:0] req_addr_o,
  input  logic                       req_ready_i,
  input  logic                       rsp_valid_i,
  input  logic [INST_DATA_WIDTH-1:0] rsp_data_i,
  output logic [INST_DATA_WIDTH-1:0] inst_o,
  output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
`ifdef IFU_MISALIGN_CHK_EN
  output logic                       misalign_o,
`endif
  output logic                       inst_valid_o
);

  localparam int OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int TAG_DEPTH = (MAX_OUTSTANDING < 2) ? 2 : (1 << $clog2(MAX_OUTSTANDING));
  localparam int TCW       = $clog2(TAG_DEPTH) + 1;
  localparam int EW        = $bits(fetch_entry_t);

  logic [INST_ADDR_WIDTH-1:0] pc;
  logic [INST_ADDR_WIDTH-1:0] jump_target;
  logic [OW-1:0]              outstanding;
  logic [OW-1:0]              outstanding_nxt;
  logic [OW-1:0]              drop_cnt;
  logic                       issue_block;
  logic                       credit_ok;
  logic                       handshake;
  logic                       rsp_keep;
  logic                       inst_pop;

  logic [EW-1:0]              inst_head_raw;
  fetch_entry_t               inst_head;
  logic [CW-1:0]              inst_count;
  logic                       inst_empty;
  logic                       inst_full;

  logic [INST_ADDR_WIDTH-1:0] tag_head;
  logic [TCW-1:0]             tag_count;
  logic                       tag_empty;
  logic                       tag_full;

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign;

  assign jump_target = jump_addr_i;
  assign issue_block = misalign;
  assign misalign_o  = misalign;

  always_ff @(posedge clk) begin
    if (rst)              misalign <= 1'b0;
    else if (jump_flag_i) misalign <= (jump_addr_i[1:0] != 2'b00);
  end
`else
  assign jump_target = align_word(jump_addr_i);
  assign issue_block = 1'b0;
`endif

  // Count in-flight requests against both limits so every response is guaranteed a FIFO slot.
  assign credit_ok = (int'(outstanding) < MAX_OUTSTANDING) &&
                     (int'(outstanding) + int'(inst_count) < FIFO_DEPTH);

  assign req_valid_o     = !rst && !jump_flag_i && !issue_block && credit_ok;
  assign req_addr_o      = pc;
  assign handshake       = req_valid_o && req_ready_i;
  assign outstanding_nxt = outstanding + OW'(handshake) - OW'(rsp_valid_i);

  assign rsp_keep     = rsp_valid_i && (drop_cnt == '0) && !jump_flag_i;
  assign inst_valid_o = !inst_empty;
  assign inst_pop     = inst_valid_o && (hold_flag_i < Hold_If) && !jump_flag_i;
  assign inst_head    = fetch_entry_t'(inst_head_raw);
  assign inst_o       = inst_empty ? INST_NOP : inst_head.data;
  assign inst_addr_o  = inst_empty ? ZeroWord : inst_head.addr;

  ifu_inst_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data ({tag_head, rsp_data_i}),
    .pop       (inst_pop),
    .flush     (jump_flag_i),
    .head      (inst_head_raw),
    .count     (inst_count),
    .empty     (inst_empty),
    .full      (inst_full)
  );

  // Tag queue pops on every response, stale or not, so it always tracks the memory's order.
  ifu_inst_fifo #(
    .WIDTH (INST_ADDR_WIDTH),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (handshake),
    .push_data (pc),
    .pop       (rsp_valid_i),
    .flush     (1'b0),
    .head      (tag_head),
    .count     (tag_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (jump_flag_i) begin
        pc       <= jump_target;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (handshake) pc <= pc + 32'd4;
        if (rsp_valid_i && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rsp_keep && inst_full));
      assert (!(rsp_valid_i && tag_empty));
      assert (!(handshake && tag_full));
      assert (int'(outstanding) == int'(tag_count));
    end
  end

endmodule
